execute_pipe: RTL and testbench

//  Parametrised integer execute stage, sitting between decode and memory. Selects operands

---
 rtl/execute_pipe.sv | 215 +++++++++++++++++++++
 tb/tb_execute_pipe.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_pipe.sv
// execute_pipe: integer execute stage with operand forwarding, single-cycle ALU and a
// valid/ready output register. Define EXEC_MULDIV_EN to build the iterative MUL/DIV unit.
module execute_pipe #(
   parameter int XLEN       = 32,
   parameter int NUM_FWD    = 2,
   parameter int REG_ADDR_W = 5,
   localparam int FSEL_W    = $clog2(NUM_FWD + 1),
   localparam int SH_W      = $clog2(XLEN)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [3:0]                op,
   input  logic [XLEN-1:0]           rs1_data,
   input  logic [XLEN-1:0]           rs2_data,
   input  logic [XLEN-1:0]           imm,
   input  logic                      src1_sel,
   input  logic                      src2_sel,
   input  logic [FSEL_W-1:0]         fwd_sel1,
   input  logic [FSEL_W-1:0]         fwd_sel2,
   input  logic [NUM_FWD*XLEN-1:0]   fwd_data,
   input  logic [REG_ADDR_W-1:0]     rd_addr,
   input  logic                      reg_write,
   input  logic                      mem_write,
   input  logic [1:0]                wb_sel,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [XLEN-1:0]           result,
   output logic [XLEN-1:0]           store_data,
   output logic [REG_ADDR_W-1:0]     rd_addr_out,
   output logic                      reg_write_out,
   output logic                      mem_write_out,
   output logic [1:0]                wb_sel_out,
   output logic                      illegal_op
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
   state_t state;

   logic [XLEN-1:0] fwd1, fwd2, in1, in2;
   logic [XLEN-1:0] alu_res;
   logic            alu_ill;
   logic [SH_W-1:0] shamt;
   logic            slot_free, accept, load;
   logic [XLEN-1:0] ld_res, ld_store;
   logic [REG_ADDR_W-1:0] ld_rd;
   logic            ld_rw, ld_mw, ld_ill;
   logic [1:0]      ld_wb;

   // Out-of-range forwarding selects fall back to the register-file value.
   always_comb begin
      fwd1 = rs1_data;
      fwd2 = rs2_data;
      for (int unsigned k = 1; k <= NUM_FWD; k++) begin
         if (fwd_sel1 == FSEL_W'(k)) fwd1 = fwd_data[(k-1)*XLEN +: XLEN];
         if (fwd_sel2 == FSEL_W'(k)) fwd2 = fwd_data[(k-1)*XLEN +: XLEN];
      end
   end

   assign in1   = src1_sel ? imm : fwd1;
   assign in2   = src2_sel ? imm : fwd2;
   assign shamt = in2[SH_W-1:0];

   always_comb begin
      alu_res = '0;
      alu_ill = 1'b0;
      case (op)
         4'd0:    alu_res = in1 + in2;
         4'd1:    alu_res = in1 - in2;
         4'd2:    alu_res = in1 & in2;
         4'd3:    alu_res = in1 | in2;
         4'd4:    alu_res = in1 ^ in2;
         4'd5:    alu_res = {{(XLEN-1){1'b0}}, $signed(in1) < $signed(in2)};
         4'd6:    alu_res = {{(XLEN-1){1'b0}}, in1 < in2};
         4'd7:    alu_res = in1 << shamt;
         4'd8:    alu_res = in1 >> shamt;
         4'd9:    alu_res = XLEN'($signed(in1) >>> shamt);
         4'd10:   alu_res = in2;
         default: alu_ill = 1'b1;
      endcase
   end

   assign slot_free = !out_valid || out_ready;
   assign in_ready  = (state == IDLE) && slot_free && !flush;
   assign accept    = in_valid && in_ready;

`ifdef EXEC_MULDIV_EN
   state_t                state_nxt;
   logic [SH_W-1:0]       cnt;
   logic [XLEN-1:0]       acc_hi, acc_lo, opnd, md_res, md_store;
   logic [3:0]            md_op;
   logic [REG_ADDR_W-1:0] md_rd;
   logic                  md_rw, md_mw, md_load, is_md, is_mul;
   logic [1:0]            md_wb;
   logic [XLEN:0]         mul_sum, div_shift, div_diff;

   assign is_md  = (op >= 4'd11) && (op <= 4'd14);
   assign is_mul = (op == 4'd11) || (op == 4'd12);

   // acc_hi:acc_lo is the product for MUL and remainder:quotient for DIV.
   assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
   assign div_shift = {acc_hi, acc_lo[XLEN-1]};
   assign div_diff  = div_shift - {1'b0, opnd};
   assign md_res    = ((md_op == 4'd12) || (md_op == 4'd14)) ? acc_hi : acc_lo;

   always_comb begin
      state_nxt = state;
      md_load   = 1'b0;
      case (state)
         IDLE:     if (accept && is_md) state_nxt = is_mul ? MUL : DIV;
         MUL, DIV: if (cnt == SH_W'(XLEN-1)) state_nxt = DONE;
         DONE:     if (slot_free) begin
                      state_nxt = IDLE;
                      md_load   = 1'b1;
                   end
         default:  state_nxt = IDLE;
      endcase
      if (flush) begin
         state_nxt = IDLE;
         md_load   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         opnd     <= '0;
         md_op    <= '0;
         md_store <= '0;
         md_rd    <= '0;
         md_rw    <= 1'b0;
         md_mw    <= 1'b0;
         md_wb    <= '0;
      end else begin
         state <= state_nxt;
         if (accept && is_md) begin
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= is_mul ? in2 : in1;
            opnd     <= is_mul ? in1 : in2;
            md_op    <= op;
            md_store <= fwd2;
            md_rd    <= rd_addr;
            md_rw    <= reg_write;
            md_mw    <= mem_write;
            md_wb    <= wb_sel;
         end else if (state == MUL) begin
            acc_hi <= mul_sum[XLEN:1];
            acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
            cnt    <= cnt + 1'b1;
         end else if (state == DIV) begin
            if (!div_diff[XLEN]) begin
               acc_hi <= div_diff[XLEN-1:0];
               acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
            end else begin
               acc_hi <= div_shift[XLEN-1:0];
               acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign load     = (accept && !is_md) || md_load;
   assign ld_res   = md_load ? md_res   : alu_res;
   assign ld_store = md_load ? md_store : fwd2;
   assign ld_rd    = md_load ? md_rd    : rd_addr;
   assign ld_rw    = md_load ? md_rw    : reg_write;
   assign ld_mw    = md_load ? md_mw    : mem_write;
   assign ld_wb    = md_load ? md_wb    : wb_sel;
   assign ld_ill   = md_load ? 1'b0     : alu_ill;
`else
   assign state    = IDLE;
   assign load     = accept;
   assign ld_res   = alu_res;
   assign ld_store = fwd2;
   assign ld_rd    = rd_addr;
   assign ld_rw    = reg_write;
   assign ld_mw    = mem_write;
   assign ld_wb    = wb_sel;
   assign ld_ill   = alu_ill;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid     <= 1'b0;
         result        <= '0;
         store_data    <= '0;
         rd_addr_out   <= '0;
         reg_write_out <= 1'b0;
         mem_write_out <= 1'b0;
         wb_sel_out    <= '0;
         illegal_op    <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (load) begin
         out_valid     <= 1'b1;
         result        <= ld_res;
         store_data    <= ld_store;
         rd_addr_out   <= ld_rd;
         reg_write_out <= ld_rw;
         mem_write_out <= ld_mw;
         wb_sel_out    <= ld_wb;
         illegal_op    <= ld_ill;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_execute_pipe.sv
// Self-checking bench for execute_pipe: directed literal cases plus randomized traffic
// compared every cycle against a transaction-level model (honours EXEC_MULDIV_EN).
module tb_execute_pipe;
   localparam int XLEN       = 32;
   localparam int NUM_FWD    = 2;
   localparam int REG_ADDR_W = 5;
   localparam int FSEL_W     = $clog2(NUM_FWD + 1);
`ifdef EXEC_MULDIV_EN
   localparam bit MULDIV = 1'b1;
`else
   localparam bit MULDIV = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic flush = 1'b0, in_valid = 1'b0, in_ready;
   logic [3:0] op = '0;
   logic [XLEN-1:0] rs1_data = '0, rs2_data = '0, imm = '0;
   logic src1_sel = 1'b0, src2_sel = 1'b0;
   logic [FSEL_W-1:0] fwd_sel1 = '0, fwd_sel2 = '0;
   logic [XLEN-1:0] fv [NUM_FWD];
   logic [NUM_FWD*XLEN-1:0] fwd_data;
   logic [REG_ADDR_W-1:0] rd_addr = '0;
   logic reg_write = 1'b0, mem_write = 1'b0;
   logic [1:0] wb_sel = '0;
   logic out_valid, out_ready = 1'b1;
   logic [XLEN-1:0] result, store_data;
   logic [REG_ADDR_W-1:0] rd_addr_out;
   logic reg_write_out, mem_write_out, illegal_op;
   logic [1:0] wb_sel_out;

   assign fwd_data = {fv[1], fv[0]};

   execute_pipe #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .REG_ADDR_W(REG_ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
      .src1_sel(src1_sel), .src2_sel(src2_sel), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
      .fwd_data(fwd_data), .rd_addr(rd_addr), .reg_write(reg_write), .mem_write(mem_write),
      .wb_sel(wb_sel), .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .store_data(store_data), .rd_addr_out(rd_addr_out), .reg_write_out(reg_write_out),
      .mem_write_out(mem_write_out), .wb_sel_out(wb_sel_out), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] res;
      logic [31:0] st;
      logic [4:0]  rd;
      logic        rw;
      logic        mw;
      logic [1:0]  wb;
      logic        ill;
   } rec_t;

   int   checks = 0;
   int   failures = 0;
   bit   m_valid = 1'b0;
   rec_t m_out = '0;
   bit   p_busy = 1'b0;
   int   p_wait = 0;
   rec_t p_res = '0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pick(input logic [FSEL_W-1:0] sel, input logic [31:0] rs);
      return (sel == 0) ? rs : fv[int'(sel) - 1];
   endfunction

   // {illegal, result} straight from the opcode table.
   function automatic logic [32:0] ref_op(input logic [3:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
`ifdef EXEC_MULDIV_EN
      logic [63:0] p;
      p = {32'h0, a} * {32'h0, b};
`endif
      case (o)
         4'd0:  return {1'b0, a + b};
         4'd1:  return {1'b0, a - b};
         4'd2:  return {1'b0, a & b};
         4'd3:  return {1'b0, a | b};
         4'd4:  return {1'b0, a ^ b};
         4'd5:  return {1'b0, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0};
         4'd6:  return {1'b0, (a < b) ? 32'd1 : 32'd0};
         4'd7:  return {1'b0, a << (b % 32)};
         4'd8:  return {1'b0, a >> (b % 32)};
         4'd9:  return {1'b0, 32'($signed(a) >>> (b % 32))};
         4'd10: return {1'b0, b};
`ifdef EXEC_MULDIV_EN
         4'd11: return {1'b0, p[31:0]};
         4'd12: return {1'b0, p[63:32]};
         4'd13: return {1'b0, (b == 0) ? 32'hFFFF_FFFF : a / b};
         4'd14: return {1'b0, (b == 0) ? a : a % b};
`endif
         default: return {1'b1, 32'h0};
      endcase
   endfunction

   function automatic bit model_ready();
      return !p_busy && (!m_valid || out_ready) && !flush;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_out   = '0;
      p_busy  = 1'b0;
      p_wait  = 0;
   endtask

   task automatic model_update();
      logic [31:0] a, b2, b;
      logic [32:0] r;
      rec_t rec;
      bit free;
      free = !m_valid || out_ready;
      if (flush) begin
         m_valid = 1'b0;
         p_busy  = 1'b0;
      end else if (!p_busy && free && in_valid) begin
         a   = src1_sel ? imm : pick(fwd_sel1, rs1_data);
         b2  = pick(fwd_sel2, rs2_data);
         b   = src2_sel ? imm : b2;
         r   = ref_op(op, a, b);
         rec = '{res: r[31:0], st: b2, rd: rd_addr, rw: reg_write, mw: mem_write,
                 wb: wb_sel, ill: r[32]};
         if (MULDIV && op >= 4'd11 && op <= 4'd14) begin
            p_busy  = 1'b1;
            p_wait  = XLEN;
            p_res   = rec;
            m_valid = 1'b0;
         end else begin
            m_out   = rec;
            m_valid = 1'b1;
         end
      end else if (p_busy && p_wait > 0) begin
         p_wait--;
         if (out_ready) m_valid = 1'b0;
      end else if (p_busy && free) begin
         m_out   = p_res;
         m_valid = 1'b1;
         p_busy  = 1'b0;
      end else if (out_ready) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic compare();
      rec_t act;
      check("in_ready", in_ready, model_ready());
      check("out_valid", out_valid, m_valid);
      if (m_valid) begin
         act = {result, store_data, rd_addr_out, reg_write_out, mem_write_out, wb_sel_out,
                illegal_op};
         check("outputs", act, m_out);
      end
   endtask

   // Inputs are applied at the negedge before each call.
   task automatic cycle();
      #1;
      compare();
      @(posedge clk);
      if (rst_n) model_update();
      else model_reset();
      @(negedge clk);
   endtask

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 40));
         default: return $urandom();
      endcase
   endfunction

   task automatic set_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      op = o; rs1_data = a; rs2_data = b; imm = '0;
      src1_sel = 1'b0; src2_sel = 1'b0; fwd_sel1 = '0; fwd_sel2 = '0;
      rd_addr = 5'(o) + 5'd1; reg_write = 1'b1; mem_write = 1'b0; wb_sel = 2'd1;
   endtask

   task automatic randomize_inputs();
      in_valid  = ($urandom_range(0, 9) < 7);
      op        = 4'($urandom_range(0, 15));
      rs1_data  = rnd_val();
      rs2_data  = rnd_val();
      imm       = rnd_val();
      fv[0]     = rnd_val();
      fv[1]     = rnd_val();
      src1_sel  = 1'($urandom_range(0, 1));
      src2_sel  = 1'($urandom_range(0, 1));
      fwd_sel1  = FSEL_W'($urandom_range(0, NUM_FWD));
      fwd_sel2  = FSEL_W'($urandom_range(0, NUM_FWD));
      rd_addr   = 5'($urandom_range(0, 31));
      reg_write = 1'($urandom_range(0, 1));
      mem_write = 1'($urandom_range(0, 1));
      wb_sel    = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 29) == 0);
   endtask

`ifdef EXEC_MULDIV_EN
   task automatic md_run(input string nm, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
      int n;
      set_op(o, a, b);
      in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
      cycle();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 60) begin
         cycle();
         n++;
      end
      check({nm, "_latency"}, n, XLEN + 1);
      check(nm, result, exp);
   endtask
`endif

   initial begin
      int seen;
      fv[0] = '0;
      fv[1] = '0;
      #2 rst_n = 1'b0;
      #1;
      check("reset_valid", out_valid, 1'b0);
      check("reset_result", result, 32'h0);
      check("reset_illegal", illegal_op, 1'b0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      set_op(4'd0, 32'd5, 32'd7);
      rd_addr = 5'd9; wb_sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
      cycle();
      check("add_valid", out_valid, 1'b1);
      check("add_result", result, 32'd12);
      check("add_store", store_data, 32'd7);
      check("add_rd", rd_addr_out, 5'd9);
      check("add_wb", wb_sel_out, 2'd2);

      set_op(4'd0, 32'd3, 32'd4);
      fv[1] = 32'hFFFF_FFFF; fwd_sel1 = 2'd2; src2_sel = 1'b1; imm = 32'd1;
      cycle();
      check("fwd_add", result, 32'h0);

      set_op(4'd9, 32'h8000_0000, 32'd33);
      cycle();
      check("sra", result, 32'hC000_0000);

      set_op(4'd1, 32'd10, 32'd3);
      out_ready = 1'b0;
      #1 check("stall_ready", in_ready, 1'b0);
      cycle();
      check("stall_hold", result, 32'hC000_0000);
      check("stall_valid", out_valid, 1'b1);
      out_ready = 1'b1;
      #1 check("release_ready", in_ready, 1'b1);
      cycle();
      check("sub_after_stall", result, 32'd7);

`ifdef EXEC_MULDIV_EN
      md_run("mulhu", 4'd12, 32'hFFFF_FFFF, 32'd2, 32'd1);
      md_run("mul", 4'd11, 32'd1234, 32'd5678, 32'd7006652);
      md_run("divu", 4'd13, 32'd100, 32'd7, 32'd14);
      md_run("remu", 4'd14, 32'd100, 32'd7, 32'd2);
      md_run("divu_zero", 4'd13, 32'd55, 32'd0, 32'hFFFF_FFFF);
      md_run("remu_zero", 4'd14, 32'd55, 32'd0, 32'd55);

      set_op(4'd13, 32'd100, 32'd7);
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
      repeat (9) cycle();
      set_op(4'd0, 32'd1, 32'd1);
      flush = 1'b1; in_valid = 1'b1;
      cycle();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_valid", out_valid, 1'b0);
      #1 check("flush_ready", in_ready, 1'b1);
      seen = 0;
      repeat (40) begin
         cycle();
         if (out_valid) seen++;
      end
      check("flush_no_result", seen, 0);
`else
      set_op(4'd11, 32'd3, 32'd4);
      in_valid = 1'b1;
      cycle();
      check("mul_off_valid", out_valid, 1'b1);
      check("mul_off_result", result, 32'h0);
      check("mul_off_illegal", illegal_op, 1'b1);
`endif

      set_op(4'd15, 32'd9, 32'd9);
      in_valid = 1'b1;
      cycle();
      check("op15_illegal", illegal_op, 1'b1);
      check("op15_result", result, 32'h0);

      for (int i = 0; i < 3000; i++) begin
         randomize_inputs();
         cycle();
      end

      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      repeat (40) cycle();
      set_op(4'd0, 32'd1, 32'd1);
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0; out_ready = 1'b0;
      check("pre_reset_result", result, 32'd2);
      #2 rst_n = 1'b0;
      #1;
      check("midreset_valid", out_valid, 1'b0);
      check("midreset_result", result, 32'h0);
      check("midreset_store", store_data, 32'h0);
      check("midreset_rd", rd_addr_out, 5'd0);
      check("midreset_rw", reg_write_out, 1'b0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 200; i++) begin
         randomize_inputs();
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
